// File: rtl/fx_pkg.sv
// Shared definitions for the fx bus hub: address field positions, hub
// register map, read FSM states and the decode result record.
package fx_pkg;

  // mod_id field inside a 16-bit fx bus address
  localparam int FX_ID_MSB = 13;
  localparam int FX_ID_LSB = 8;
  localparam int FX_ID_W   = FX_ID_MSB - FX_ID_LSB + 1;

  // Width of a slave index (up to 16 slaves)
  localparam int SEL_W = 4;

  // Width of the read latency down-counter (RD_LAT up to 7)
  localparam int LAT_W = 3;

  // Hub register offsets (read side)
  localparam logic [7:0] HUB_OFF_STATUS   = 8'h00;
  localparam logic [7:0] HUB_OFF_CNT_RD   = 8'h01;
  localparam logic [7:0] HUB_OFF_CNT_MISS = 8'h02;
  localparam logic [7:0] HUB_OFF_CNT_DROP = 8'h03;

  // Hub control register (write side): bit 0 clears all counters
  localparam logic [7:0] HUB_OFF_CTRL = 8'h00;

  // Read FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fx_state_e;

  // Result of decoding one address: slave hit (with index) or hub hit.
  // Neither flag set means the address is unmapped.
  typedef struct packed {
    logic             slv;
    logic             hub;
    logic [SEL_W-1:0] idx;
  } fx_dec_t;

endpackage

// File: rtl/fx_sat_cnt.sv
// Saturating up-counter with synchronous clear. Clear has priority over
// increment; the count sticks at all-ones instead of wrapping.
module fx_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Count register: clear wins, then saturating increment
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/fx_bus_hub.sv
// fx bus hub: joins the fx bus master to N_SLV fx slaves. Decodes mod_id
// from the bus address, generates registered one-hot write strobes, and
// returns the addressed slave's read data (or a hub register, or ERR_Q for
// an unmapped read) RD_LAT+1 cycles after the read strobe. Only one read is
// outstanding; a read arriving while busy is dropped and counted.
module fx_bus_hub
  import fx_pkg::*;
#(
  parameter int                 N_SLV   = 4,
  parameter logic [N_SLV*6-1:0] MOD_IDS = {6'h35, 6'h34, 6'h33, 6'h32},
  parameter logic [5:0]         HUB_ID  = 6'h31,
  parameter int                 RD_LAT  = 2,
  parameter logic [7:0]         ERR_Q   = 8'hEE
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [15:0]        fx_waddr,
  input  logic               fx_wr,
  input  logic [7:0]         fx_data,
  input  logic               fx_rd,
  input  logic [15:0]        fx_raddr,
  input  logic [N_SLV*8-1:0] fx_q_s,
  output logic [N_SLV-1:0]   fx_wr_sel,
  output logic [7:0]         fx_q,
  output logic               fx_q_vld,
  output logic               fx_err,
  output logic               busy
);

  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(RD_LAT - 1);
  localparam logic [7:0]       HUB_STATUS = {4'h0, 4'(N_SLV - 1)};

  // Priority decode: scanning from the top down lets the lowest matching
  // index overwrite any higher one, so duplicates resolve to the lowest.
  function automatic fx_dec_t decode(input logic [FX_ID_W-1:0] id);
    fx_dec_t d;
    d = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (id == MOD_IDS[FX_ID_W*i +: FX_ID_W]) begin
        d.slv = 1'b1;
        d.idx = SEL_W'(i);
      end
    end
    d.hub = !d.slv && (id == HUB_ID);
    return d;
  endfunction

  fx_dec_t          rd_dec;
  fx_dec_t          wr_dec;
  logic             rd_accept;
  logic             rd_drop;
  logic             rd_miss;
  logic             wr_miss;
  logic             cnt_clr;
  logic             miss_inc;

  fx_state_e        state_q;
  fx_state_e        state_d;
  logic [LAT_W-1:0] lat_q;
  logic [LAT_W-1:0] lat_d;
  logic             load;
  logic             resp_fire;

  logic [SEL_W-1:0] sel_q;
  logic             hub_q;
  logic             miss_q;
  logic [7:0]       off_q;

  logic [7:0]       cnt_rd;
  logic [7:0]       cnt_miss;
  logic [7:0]       cnt_drop;

  logic [7:0]       slv_data;
  logic [7:0]       hub_data;
  logic [7:0]       resp_data;
  logic [N_SLV-1:0] wr_sel_d;

  // Address bits the hub does not interpret; the slaves see the full buses.
  logic unused_bits;
  assign unused_bits = ^{fx_waddr[15:14], fx_raddr[15:14], fx_data[7:1]};

  // Address decode and request classification
  always_comb begin
    rd_dec    = decode(fx_raddr[FX_ID_MSB:FX_ID_LSB]);
    wr_dec    = decode(fx_waddr[FX_ID_MSB:FX_ID_LSB]);
    rd_miss   = !rd_dec.slv && !rd_dec.hub;
    wr_miss   = !wr_dec.slv && !wr_dec.hub;
    rd_accept = fx_rd && !busy;
    rd_drop   = fx_rd && busy;
    cnt_clr   = fx_wr && wr_dec.hub && (fx_waddr[7:0] == HUB_OFF_CTRL) && fx_data[0];
    miss_inc  = (rd_accept && rd_miss) || (fx_wr && wr_miss);
  end

  // Busy covers the latency window only; the response cycle can accept again.
  assign busy = (state_q == WAIT);

  // Read FSM next-state logic
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    load      = 1'b0;
    resp_fire = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (rd_accept) begin
          load    = 1'b1;
          lat_d   = LAT_INIT;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          resp_fire = 1'b1;
          state_d   = RESP;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read FSM state and latency counter registers
  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Latch the accepted read request for use at response time
  // NOTE: these fields are only consumed after a load, but they are still
  // reset so no X ever reaches the response mux after power-up.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      hub_q  <= 1'b0;
      miss_q <= 1'b0;
      off_q  <= '0;
    end else if (load) begin
      sel_q  <= rd_dec.idx;
      hub_q  <= rd_dec.hub;
      miss_q <= rd_miss;
      off_q  <= fx_raddr[7:0];
    end
  end

  // Slave read mux indexed by the latched slave index
  always_comb begin
    slv_data = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q == SEL_W'(i)) begin
        slv_data = fx_q_s[8*i +: 8];
      end
    end
  end

  // Hub register read mux; counters are sampled at response time
  always_comb begin
    case (off_q)
      HUB_OFF_STATUS:   hub_data = HUB_STATUS;
      HUB_OFF_CNT_RD:   hub_data = cnt_rd;
      HUB_OFF_CNT_MISS: hub_data = cnt_miss;
      HUB_OFF_CNT_DROP: hub_data = cnt_drop;
      default:          hub_data = 8'h00;
    endcase
  end

  // Response source select
  always_comb begin
    if (miss_q) begin
      resp_data = ERR_Q;
    end else if (hub_q) begin
      resp_data = hub_data;
    end else begin
      resp_data = slv_data;
    end
  end

  // Response registers: fx_q holds until the next response
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_q     <= '0;
      fx_q_vld <= 1'b0;
      fx_err   <= 1'b0;
    end else begin
      fx_q_vld <= resp_fire;
      fx_err   <= resp_fire && miss_q;
      if (resp_fire) begin
        fx_q <= resp_data;
      end
    end
  end

  // One-hot write strobe for the decoded slave
  always_comb begin
    wr_sel_d = '0;
    for (int i = 0; i < N_SLV; i++) begin
      wr_sel_d[i] = fx_wr && wr_dec.slv && (wr_dec.idx == SEL_W'(i));
    end
  end

  // Write strobe register: high for exactly the cycle after fx_wr
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      fx_wr_sel <= '0;
    end else begin
      fx_wr_sel <= wr_sel_d;
    end
  end

  fx_sat_cnt #(.W(8)) u_cnt_rd (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (rd_accept),
    .q       (cnt_rd)
  );

  fx_sat_cnt #(.W(8)) u_cnt_miss (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (miss_inc),
    .q       (cnt_miss)
  );

  fx_sat_cnt #(.W(8)) u_cnt_drop (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (rd_drop),
    .q       (cnt_drop)
  );

endmodule

// File: tb/tb_fx_bus_hub.sv
// Self-checking bench for fx_bus_hub: directed scenarios followed by random
// bus traffic, every cycle compared against a transaction-level model.
module tb_fx_bus_hub;

  localparam int N_SLV  = 4;
  localparam int RD_LAT = 2;

  logic               clk_sys = 1'b0;
  logic               rst_n   = 1'b0;
  logic [15:0]        fx_waddr = '0;
  logic               fx_wr    = 1'b0;
  logic [7:0]         fx_data  = '0;
  logic               fx_rd    = 1'b0;
  logic [15:0]        fx_raddr = '0;
  logic [N_SLV*8-1:0] fx_q_s   = '0;
  logic [N_SLV-1:0]   fx_wr_sel;
  logic [7:0]         fx_q;
  logic               fx_q_vld;
  logic               fx_err;
  logic               busy;

  fx_bus_hub #(
    .N_SLV   (N_SLV),
    .MOD_IDS ({6'h35, 6'h34, 6'h33, 6'h32}),
    .HUB_ID  (6'h31),
    .RD_LAT  (RD_LAT),
    .ERR_Q   (8'hEE)
  ) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .fx_waddr  (fx_waddr),
    .fx_wr     (fx_wr),
    .fx_data   (fx_data),
    .fx_rd     (fx_rd),
    .fx_raddr  (fx_raddr),
    .fx_q_s    (fx_q_s),
    .fx_wr_sel (fx_wr_sel),
    .fx_q      (fx_q),
    .fx_q_vld  (fx_q_vld),
    .fx_err    (fx_err),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int slv_ids[N_SLV] = '{'h32, 'h33, 'h34, 'h35};
  localparam int HUB = 'h31;
  localparam int K_HUB  = -1;
  localparam int K_MISS = -2;

  int         cyc;
  int         m_rd, m_miss, m_drop;
  bit         m_pend;
  int         m_acc, m_kind, m_off;
  logic [7:0] e_q;
  bit         e_vld, e_err;
  logic [3:0] e_sel;

  // Slave index for an address, or K_HUB / K_MISS
  function automatic int lookup(input logic [15:0] a);
    int id;
    id = (int'(a) >> 8) & 'h3F;
    for (int i = 0; i < N_SLV; i++)
      if (slv_ids[i] == id) return i;
    if (id == HUB) return K_HUB;
    return K_MISS;
  endfunction

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_reset();
    cyc = 0; m_rd = 0; m_miss = 0; m_drop = 0;
    m_pend = 0; m_acc = 0; m_kind = 0; m_off = 0;
    e_q = 8'h00; e_vld = 0; e_err = 0; e_sel = '0;
  endtask

  // Advance the model across the clock edge that ends cycle 'cyc'
  task automatic model_step(input bit rd, input logic [15:0] ra, input bit wr,
                            input logic [15:0] wa, input logic [7:0] wd);
    bit busy_now, acc, clr;
    int rk, wk;
    logic [7:0] v;
    logic [31:0] qs;
    busy_now = m_pend && (cyc > m_acc);
    rk = lookup(ra);
    wk = lookup(wa);
    e_vld = 0; e_err = 0;
    if (m_pend && cyc == m_acc + RD_LAT) begin
      qs = fx_q_s;
      if (m_kind == K_MISS) begin
        v = 8'hEE; e_err = 1;
      end else if (m_kind == K_HUB) begin
        case (m_off)
          0: v = 8'(N_SLV - 1);
          1: v = 8'(m_rd);
          2: v = 8'(m_miss);
          3: v = 8'(m_drop);
          default: v = 8'h00;
        endcase
      end else begin
        v = qs[8*m_kind +: 8];
      end
      e_q = v; e_vld = 1; m_pend = 0;
    end
    acc = rd && !busy_now;
    if (acc) begin
      m_pend = 1; m_acc = cyc; m_kind = rk; m_off = int'(ra[7:0]);
    end
    e_sel = (wr && wk >= 0) ? 4'(1 << wk) : 4'b0000;
    clr = wr && (wk == K_HUB) && (wa[7:0] == 8'h00) && wd[0];
    if (clr) begin
      m_rd = 0; m_miss = 0; m_drop = 0;
    end else begin
      if (acc) m_rd = sat(m_rd);
      if ((acc && rk == K_MISS) || (wr && wk == K_MISS)) m_miss = sat(m_miss);
      if (rd && busy_now) m_drop = sat(m_drop);
    end
    cyc++;
  endtask

  task automatic check_outputs();
    check("fx_q_vld", 32'(fx_q_vld), 32'(e_vld));
    check("fx_err", 32'(fx_err), 32'(e_err));
    check("fx_q", 32'(fx_q), 32'(e_q));
    check("fx_wr_sel", 32'(fx_wr_sel), 32'(e_sel));
    check("busy", 32'(busy), 32'(m_pend && (cyc > m_acc)));
  endtask

  // One bus cycle: drive after the edge, sample at the falling edge
  task automatic run_cycle(input bit rd, input logic [15:0] ra, input bit wr,
                           input logic [15:0] wa, input logic [7:0] wd);
    @(posedge clk_sys);
    #1;
    fx_rd = rd; fx_raddr = ra; fx_wr = wr; fx_waddr = wa; fx_data = wd;
    fx_q_s = $urandom;
    @(negedge clk_sys);
    check_outputs();
    model_step(rd, ra, wr, wa, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(0, 16'h0000, 0, 16'h0000, 8'h00);
  endtask

  task automatic rd_and_wait(input logic [15:0] ra);
    run_cycle(1, ra, 0, 16'h0000, 8'h00);
    idle(RD_LAT + 1);
  endtask

  // Asynchronous reset asserted away from the clock edge
  task automatic do_reset();
    @(posedge clk_sys);
    #2;
    rst_n = 1'b0;
    fx_rd = 0; fx_wr = 0;
    model_reset();
    @(negedge clk_sys);
    check_outputs();
    @(posedge clk_sys);
    @(negedge clk_sys);
    rst_n = 1'b1;
    check_outputs();
  endtask

  function automatic logic [15:0] rand_raddr();
    int r;
    logic [5:0] id;
    r = $urandom_range(0, 9);
    if (r < 6)      id = 6'(slv_ids[$urandom_range(0, N_SLV - 1)]);
    else if (r < 8) id = 6'(HUB);
    else            id = 6'($urandom);
    return {2'($urandom), id, (r >= 6 && r < 8) ? 8'($urandom_range(0, 5)) : 8'($urandom)};
  endfunction

  function automatic logic [15:0] rand_waddr();
    int r;
    logic [5:0] id;
    r = $urandom_range(0, 19);
    if (r < 14)      id = 6'(slv_ids[$urandom_range(0, N_SLV - 1)]);
    else if (r == 14) id = 6'(HUB);
    else             id = 6'($urandom);
    return {2'($urandom), id, (r == 14) ? 8'($urandom_range(0, 1)) : 8'($urandom)};
  endfunction

  initial begin
    bit rd, wr;
    logic [15:0] ra, wa;

    model_reset();
    do_reset();

    // Slave read, unmapped read, miss counter
    rd_and_wait(16'h3310);
    rd_and_wait(16'h3F00);
    rd_and_wait(16'h3102);
    rd_and_wait(16'h3100);
    rd_and_wait(16'h3107);

    // Mapped and unmapped writes
    run_cycle(0, 16'h0000, 1, 16'h3405, 8'h5A);
    idle(2);
    run_cycle(0, 16'h0000, 1, 16'h3A00, 8'h11);
    idle(2);

    // Back-to-back reads: second one dropped
    do_reset();
    run_cycle(1, 16'h3210, 0, 16'h0000, 8'h00);
    run_cycle(1, 16'h3520, 0, 16'h0000, 8'h00);
    idle(RD_LAT);
    rd_and_wait(16'h3103);
    do_reset();
    run_cycle(1, 16'h3210, 1, 16'h3301, 8'h00);
    idle(RD_LAT + 1);
    rd_and_wait(16'h3101);

    // Saturation of the miss counter, then clear
    for (int i = 0; i < 300; i++) rd_and_wait(16'h3F00);
    rd_and_wait(16'h3102);
    run_cycle(0, 16'h0000, 1, 16'h3100, 8'h01);
    rd_and_wait(16'h3101);
    rd_and_wait(16'h3102);
    rd_and_wait(16'h3103);

    // Reset during the latency window aborts the read
    run_cycle(1, 16'h3420, 0, 16'h0000, 8'h00);
    idle(1);
    do_reset();
    idle(RD_LAT + 2);
    rd_and_wait(16'h3520);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(0, 9) < 4);
      wr = ($urandom_range(0, 9) < 3);
      ra = rand_raddr();
      wa = rand_waddr();
      if (rd && wr && lookup(wa) == K_MISS) wr = 0;
      run_cycle(rd, ra, wr, wa, 8'($urandom));
    end
    idle(RD_LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
